// File: rtl/ex_serial_pkg.sv
// Shared opcode/funct3 constants and FSM state type for the serial-shift execute stage.
package rv_ops;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OPIMM  = 7'h13;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] BUBBLE = 7'h00;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

endpackage

// File: rtl/ex_serial_shifter.sv
// Multi-cycle shifter: moves the latched operand by up to SHIFT_STEP bits per enabled cycle.
module serial_shifter #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step_en,
  input  logic [31:0] operand,
  input  logic [4:0]  shamt,
  input  logic        left,
  input  logic        arith,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [5:0] STEP_W = 6'(SHIFT_STEP);

  logic [31:0] val_r;
  logic [5:0]  rem_r;
  logic        left_r;
  logic        arith_r;
  logic        sign_r;
  logic [5:0]  step_s;
  logic [31:0] fill_s;

  // Step size and value after this cycle's step; sign fill comes from the issue-time sign.
  always_comb begin
    step_s = 6'd0;
    fill_s = 32'h0000_0000;
    result = 32'h0000_0000;
    if (rem_r < STEP_W) begin
      step_s = rem_r;
    end else begin
      step_s = STEP_W;
    end
    if (arith_r && sign_r) begin
      fill_s = ~(32'hFFFF_FFFF >> step_s);
    end else begin
      fill_s = 32'h0000_0000;
    end
    if (left_r) begin
      result = val_r << step_s;
    end else begin
      result = (val_r >> step_s) | fill_s;
    end
    done = (rem_r <= STEP_W);
  end

  // Operand capture on start, then one step per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_r   <= 32'h0000_0000;
      rem_r   <= 6'd0;
      left_r  <= 1'b0;
      arith_r <= 1'b0;
      sign_r  <= 1'b0;
    end else if (start) begin
      val_r   <= operand;
      rem_r   <= {1'b0, shamt};
      left_r  <= left;
      arith_r <= arith;
      sign_r  <= operand[31];
    end else if (step_en) begin
      val_r <= result;
      rem_r <= rem_r - step_s;
    end
  end

endmodule

// File: rtl/ex_serial.sv
// Execute stage: single-cycle ALU, serial shifter with upstream stall, EX/MEM register and forwarding bus.
module ex_serial
  import rv_ops::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ex_t,
  input  logic [2:0]  ex_st,
  input  logic        ex_sst,
  input  logic [31:0] ex_n1,
  input  logic [31:0] ex_n2,
  input  logic [4:0]  ex_wa,
  input  logic        ex_we,
  output logic        stall_req,
  output logic [31:0] mem_wd,
  output logic [4:0]  mem_wa,
  output logic        mem_we,
  output logic [31:0] fwd_wd,
  output logic [4:0]  fwd_wa,
  output logic        fwd_we
);

  state_t      state_r;
  logic [4:0]  lat_wa_r;
  logic        lat_we_r;
  logic        is_alu_s;
  logic        valid_s;
  logic        start_s;
  logic        we_eff_s;
  logic [31:0] alu_s;
  logic        sh_done_s;
  logic [31:0] sh_result_s;

  assign is_alu_s = (ex_t == OP) || (ex_t == OPIMM);
  assign valid_s  = is_alu_s || (ex_t == LUI) || (ex_t == AUIPC);
  assign start_s  = is_alu_s && ((ex_st == F3_SLL) || (ex_st == F3_SR)) && (ex_n2[4:0] != 5'd0);
  assign we_eff_s = valid_s && ex_we && (ex_wa != 5'd0);

  // Single-cycle result; a zero-amount shift passes operand 1 through unchanged.
  always_comb begin
    alu_s = 32'h0000_0000;
    case (ex_t)
      OP, OPIMM: begin
        case (ex_st)
          F3_ADD:  alu_s = (ex_t == OP && ex_sst) ? (ex_n1 - ex_n2) : (ex_n1 + ex_n2);
          F3_SLL:  alu_s = ex_n1;
          F3_SLT:  alu_s = {31'd0, $signed(ex_n1) < $signed(ex_n2)};
          F3_SLTU: alu_s = {31'd0, ex_n1 < ex_n2};
          F3_XOR:  alu_s = ex_n1 ^ ex_n2;
          F3_SR:   alu_s = ex_n1;
          F3_OR:   alu_s = ex_n1 | ex_n2;
          F3_AND:  alu_s = ex_n1 & ex_n2;
          default: alu_s = 32'h0000_0000;
        endcase
      end
      LUI:     alu_s = ex_n2;
      AUIPC:   alu_s = ex_n1 + ex_n2;
      default: alu_s = 32'h0000_0000;
    endcase
  end

  serial_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   ((state_r == IDLE) && start_s),
    .step_en (state_r == BUSY),
    .operand (ex_n1),
    .shamt   (ex_n2[4:0]),
    .left    (ex_st == F3_SLL),
    .arith   (ex_sst),
    .done    (sh_done_s),
    .result  (sh_result_s)
  );

  // Stall and forwarding are combinational so ID sees them in the completing cycle.
  always_comb begin
    stall_req = 1'b0;
    fwd_wd    = 32'h0000_0000;
    fwd_wa    = 5'd0;
    fwd_we    = 1'b0;
    if (rst) begin
      stall_req = 1'b0;
    end else if (state_r == BUSY) begin
      if (sh_done_s) begin
        fwd_wd = sh_result_s;
        fwd_wa = lat_wa_r;
        fwd_we = lat_we_r;
      end else begin
        stall_req = 1'b1;
      end
    end else if (start_s) begin
      stall_req = 1'b1;
    end else begin
      fwd_wd = alu_s;
      fwd_wa = valid_s ? ex_wa : 5'd0;
      fwd_we = we_eff_s;
    end
  end

  // Control FSM and EX/MEM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      lat_wa_r <= 5'd0;
      lat_we_r <= 1'b0;
      mem_wd   <= 32'h0000_0000;
      mem_wa   <= 5'd0;
      mem_we   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            lat_wa_r <= ex_wa;
            lat_we_r <= we_eff_s;
            state_r  <= BUSY;
            mem_wd   <= 32'h0000_0000;
            mem_wa   <= 5'd0;
            mem_we   <= 1'b0;
          end else begin
            mem_wd <= alu_s;
            mem_wa <= valid_s ? ex_wa : 5'd0;
            mem_we <= we_eff_s;
          end
        end
        BUSY: begin
          if (sh_done_s) begin
            mem_wd  <= sh_result_s;
            mem_wa  <= lat_wa_r;
            mem_we  <= lat_we_r;
            state_r <= IDLE;
          end else begin
            mem_wd <= 32'h0000_0000;
            mem_wa <= 5'd0;
            mem_we <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          mem_wd  <= 32'h0000_0000;
          mem_wa  <= 5'd0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_serial.sv
// Self-checking bench: two instances (SHIFT_STEP 1 and 4) driven in lockstep from vectors and random ops.
module tb_ex_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  ex_t;
  logic [2:0]  ex_st;
  logic        ex_sst;
  logic [31:0] ex_n1;
  logic [31:0] ex_n2;
  logic [4:0]  ex_wa;
  logic        ex_we;

  logic        stall_a  [2];
  logic [31:0] mem_wd_a [2];
  logic [4:0]  mem_wa_a [2];
  logic        mem_we_a [2];
  logic [31:0] fwd_wd_a [2];
  logic [4:0]  fwd_wa_a [2];
  logic        fwd_we_a [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_serial #(.SHIFT_STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .ex_t(ex_t), .ex_st(ex_st), .ex_sst(ex_sst),
    .ex_n1(ex_n1), .ex_n2(ex_n2), .ex_wa(ex_wa), .ex_we(ex_we),
    .stall_req(stall_a[0]), .mem_wd(mem_wd_a[0]), .mem_wa(mem_wa_a[0]), .mem_we(mem_we_a[0]),
    .fwd_wd(fwd_wd_a[0]), .fwd_wa(fwd_wa_a[0]), .fwd_we(fwd_we_a[0])
  );

  ex_serial #(.SHIFT_STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .ex_t(ex_t), .ex_st(ex_st), .ex_sst(ex_sst),
    .ex_n1(ex_n1), .ex_n2(ex_n2), .ex_wa(ex_wa), .ex_we(ex_we),
    .stall_req(stall_a[1]), .mem_wd(mem_wd_a[1]), .mem_wa(mem_wa_a[1]), .mem_we(mem_we_a[1]),
    .fwd_wd(fwd_wd_a[1]), .fwd_wa(fwd_wa_a[1]), .fwd_we(fwd_we_a[1])
  );

  typedef struct {
    string       name;
    logic [6:0]  t;
    logic [2:0]  st;
    logic        sst;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] exp_wd;
    logic        exp_we;
  } vec_t;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step%0d: got %h expected %h", nm, (d == 0) ? 1 : 4, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural rules, shifts done in one go.
  function automatic logic [31:0] ref_res(input logic [6:0] t, input logic [2:0] st, input logic sst,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    if (t == 7'h33 || t == 7'h13) begin
      case (st)
        3'd0: return (t == 7'h33 && sst) ? a - b : a + b;
        3'd1: return a << sh;
        3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: return sst ? 32'($signed(a) >>> sh) : a >> sh;
        3'd6: return a | b;
        default: return a & b;
      endcase
    end else if (t == 7'h37) begin
      return b;
    end else if (t == 7'h17) begin
      return a + b;
    end else begin
      return 32'd0;
    end
  endfunction

  task automatic drive_bubble();
    ex_t = 7'h00; ex_st = 3'd0; ex_sst = 1'b0; ex_n1 = 32'd0; ex_n2 = 32'd0; ex_wa = 5'd0; ex_we = 1'b0;
  endtask

  // Present one op (called #1 after a posedge), follow both DUTs to completion and check.
  task automatic do_op(input string nm, input logic [6:0] t, input logic [2:0] st, input logic sst,
                       input logic [31:0] n1, input logic [31:0] n2, input logic [4:0] wa, input logic we,
                       input logic [31:0] ewd, input logic ewe);
    int  k;
    int  exp_st [2];
    int  cnt    [2];
    bit  fin    [2];
    bit  endnow [2];
    bit  is_sh;
    is_sh = (t == 7'h33 || t == 7'h13) && (st == 3'd1 || st == 3'd5);
    k = is_sh ? int'(n2 % 32) : 0;
    exp_st[0] = k;
    exp_st[1] = (k + 3) / 4;
    cnt[0] = 0; cnt[1] = 0; fin[0] = 1'b0; fin[1] = 1'b0;
    ex_t = t; ex_st = st; ex_sst = sst; ex_n1 = n1; ex_n2 = n2; ex_wa = wa; ex_we = we;
    for (int cyc = 0; cyc < 40 && !(fin[0] && fin[1]); cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        endnow[d] = 1'b0;
        if (!fin[d]) begin
          if (stall_a[d]) begin
            cnt[d]++;
          end else begin
            chk({nm, " fwd_we"}, d, {31'd0, fwd_we_a[d]}, {31'd0, ewe});
            if (ewe) begin
              chk({nm, " fwd_wd"}, d, fwd_wd_a[d], ewd);
              chk({nm, " fwd_wa"}, d, {27'd0, fwd_wa_a[d]}, {27'd0, wa});
            end
            chk({nm, " stall_cycles"}, d, cnt[d], exp_st[d]);
            endnow[d] = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (endnow[d]) begin
          chk({nm, " mem_we"}, d, {31'd0, mem_we_a[d]}, {31'd0, ewe});
          chk({nm, " mem_wd"}, d, mem_wd_a[d], ewd);
          if (ewe) chk({nm, " mem_wa"}, d, {27'd0, mem_wa_a[d]}, {27'd0, wa});
          fin[d] = 1'b1;
        end else if (!fin[d]) begin
          chk({nm, " mem_we_busy"}, d, {31'd0, mem_we_a[d]}, 32'd0);
        end
      end
      // A finished instance must not re-issue; the busy one ignores ex_* anyway.
      if (fin[0] || fin[1]) drive_bubble();
    end
    for (int d = 0; d < 2; d++) begin
      if (!fin[d]) begin
        checks++; errors++;
        $display("FAIL %s timeout step%0d: stall_req still high after 40 cycles", nm, (d == 0) ? 1 : 4);
      end
    end
    drive_bubble();
  endtask

  vec_t vecs [15];

  initial begin
    logic [6:0]  rt;
    logic [2:0]  rst3;
    logic        rsst;
    logic [31:0] rn1, rn2, rwd;
    logic [4:0]  rwa;
    logic        rwe, rvalid;
    logic [6:0]  ops [6];

    vecs[0]  = '{"add",      7'h33, 3'd0, 1'b0, 32'd5,          32'd7,          5'd3,  1'b1, 32'd12,         1'b1};
    vecs[1]  = '{"sub",      7'h33, 3'd0, 1'b1, 32'd0,          32'd1,          5'd4,  1'b1, 32'hFFFF_FFFF,  1'b1};
    vecs[2]  = '{"slt",      7'h33, 3'd2, 1'b0, 32'hFFFF_FFFF,  32'd1,          5'd5,  1'b1, 32'd1,          1'b1};
    vecs[3]  = '{"sltu",     7'h33, 3'd3, 1'b0, 32'hFFFF_FFFF,  32'd1,          5'd6,  1'b1, 32'd0,          1'b1};
    vecs[4]  = '{"sra4",     7'h33, 3'd5, 1'b1, 32'h8000_0000,  32'd4,          5'd7,  1'b1, 32'hF800_0000,  1'b1};
    vecs[5]  = '{"sll5",     7'h33, 3'd1, 1'b0, 32'd1,          32'h25,         5'd8,  1'b1, 32'h20,         1'b1};
    vecs[6]  = '{"sll0",     7'h13, 3'd1, 1'b0, 32'h0000_ABCD,  32'h20,         5'd9,  1'b1, 32'h0000_ABCD,  1'b1};
    vecs[7]  = '{"add_x0",   7'h33, 3'd0, 1'b0, 32'd1,          32'd2,          5'd0,  1'b1, 32'd3,          1'b0};
    vecs[8]  = '{"bubble0",  7'h00, 3'd0, 1'b0, 32'd1,          32'd2,          5'd3,  1'b1, 32'd0,          1'b0};
    vecs[9]  = '{"bubble63", 7'h63, 3'd0, 1'b0, 32'd1,          32'd2,          5'd3,  1'b1, 32'd0,          1'b0};
    vecs[10] = '{"lui",      7'h37, 3'd0, 1'b0, 32'd9,          32'h1234_5000,  5'd10, 1'b1, 32'h1234_5000,  1'b1};
    vecs[11] = '{"auipc",    7'h17, 3'd0, 1'b0, 32'h1000,       32'd4,          5'd11, 1'b1, 32'h1004,       1'b1};
    vecs[12] = '{"addi_sst", 7'h13, 3'd0, 1'b1, 32'd10,         32'd3,          5'd12, 1'b1, 32'd13,         1'b1};
    vecs[13] = '{"xor",      7'h33, 3'd4, 1'b0, 32'h0000_F0F0,  32'h0000_FF00,  5'd13, 1'b1, 32'h0000_0FF0,  1'b1};
    vecs[14] = '{"srl31",    7'h13, 3'd5, 1'b0, 32'h8000_0000,  32'd31,         5'd14, 1'b0, 32'd1,          1'b0};

    drive_bubble();
    ex_t = 7'h33; ex_st = 3'd1; ex_n2 = 32'd3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset stall_req", d, {31'd0, stall_a[d]}, 32'd0);
      chk("reset fwd_we",    d, {31'd0, fwd_we_a[d]}, 32'd0);
      chk("reset mem_we",    d, {31'd0, mem_we_a[d]}, 32'd0);
      chk("reset mem_wd",    d, mem_wd_a[d], 32'd0);
      chk("reset mem_wa",    d, {27'd0, mem_wa_a[d]}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_bubble();
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].name, vecs[i].t, vecs[i].st, vecs[i].sst, vecs[i].n1, vecs[i].n2,
            vecs[i].wa, vecs[i].we, vecs[i].exp_wd, vecs[i].exp_we);
    end

    // Back-to-back shifts with no gap.
    do_op("sra_b2b_a", 7'h33, 3'd5, 1'b1, 32'hF000_000F, 32'd9, 5'd2, 1'b1, 32'hFFF8_0000, 1'b1);
    do_op("sll_b2b_b", 7'h13, 3'd1, 1'b0, 32'h0000_0003, 32'd30, 5'd2, 1'b1, 32'hC000_0000, 1'b1);

    // Reset during the second BUSY cycle of SRL by 8 discards the shift.
    ex_t = 7'h33; ex_st = 3'd5; ex_sst = 1'b0; ex_n1 = 32'hFF00_0000; ex_n2 = 32'd8; ex_wa = 5'd15; ex_we = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("rst_mid stall_req", d, {31'd0, stall_a[d]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_bubble();
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid mem_we", d, {31'd0, mem_we_a[d]}, 32'd0);
      chk("rst_mid mem_wd", d, mem_wd_a[d], 32'd0);
    end
    do_op("add_after_rst", 7'h33, 3'd0, 1'b0, 32'd100, 32'd23, 5'd1, 1'b1, 32'd123, 1'b1);

    // Randomised ops against the reference model.
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h37; ops[3] = 7'h17; ops[4] = 7'h00; ops[5] = 7'h63;
    for (int i = 0; i < 80; i++) begin
      rt   = ops[$urandom_range(0, 5)];
      if (i % 3 == 0) rt = (i % 2 == 0) ? 7'h33 : 7'h13;
      rst3 = 3'($urandom_range(0, 7));
      rsst = 1'($urandom_range(0, 1));
      rn1  = $urandom;
      rn2  = $urandom;
      rwa  = 5'($urandom_range(0, 31));
      rwe  = 1'($urandom_range(0, 1));
      rvalid = (rt == 7'h33) || (rt == 7'h13) || (rt == 7'h37) || (rt == 7'h17);
      rwd  = ref_res(rt, rst3, rsst, rn1, rn2);
      do_op("random", rt, rst3, rsst, rn1, rn2, rwa, rwe, rwd, rvalid && rwe && (rwa != 5'd0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
